// File: rtl/div4_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV4_SEQ_ZERO_EARLY_EN to finish zero-divisor requests in one cycle.
module div4_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             no_borrow;
   logic [WIDTH-1:0] q_next;

   // Trial subtract as add of inverted divisor with carry-in; carry-out = no borrow.
   always_comb begin
      shifted   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      diff      = {1'b0, shifted}
                + {1'b0, ~{1'b0, d_q}}
                + {{(WIDTH+1){1'b0}}, 1'b1};
      no_borrow = diff[WIDTH+1];
      q_next    = {q_q[WIDTH-2:0], no_borrow};
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               q_d     = dividend;
               d_d     = divisor;
               r_d     = '0;
               cnt_d   = CW'(WIDTH);
               state_d = RUN;
`ifdef DIV4_SEQ_ZERO_EARLY_EN
               if (divisor == '0) begin
                  state_d = DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            r_d   = no_borrow ? diff[WIDTH:0] : shifted;
            q_d   = q_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               quo_d   = q_next;
               rem_d   = r_d[WIDTH-1:0];
               dbz_d   = (d_q == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
